// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, coordinate type and frame-size helpers.
// Also used by the world-map lookup and the colorizer.
package vga_timing_pkg;

  typedef logic [11:0] coord_t;

  localparam coord_t COORD_INVALID = 12'hFFF;
  localparam int unsigned COORD_MAX = 4095;

  // 640x480 at 60 Hz with a 25 MHz pixel clock
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FRONT  = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BACK   = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FRONT  = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BACK   = 33;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return active + front + sync + back;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle: the timing generator drives it (master), the colorizer
// and world-map lookup consume it (slave).
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic   horiz_sync;
  logic   vert_sync;
  logic   video_on;
  logic   frame_start;
  coord_t pixel_row;
  coord_t pixel_column;

  modport master (
    output horiz_sync,
    output vert_sync,
    output video_on,
    output frame_start,
    output pixel_row,
    output pixel_column
  );

  modport slave (
    input horiz_sync,
    input vert_sync,
    input video_on,
    input frame_start,
    input pixel_row,
    input pixel_column
  );

endinterface

// File: rtl/pixel_tick_gen.sv
// Divide-by-4 pixel tick: 100 MHz system clock to a 25 MHz pixel enable.
// The first tick arrives on the 4th clock after reset deasserts.
module pixel_tick_gen (
  input  logic clock_i,
  input  logic reset_i,
  output logic tick_o
);

  logic [1:0] div_q, div_d;

  always_comb begin
    div_d = div_q + 2'd1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      div_q <= 2'd0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick_o = (div_q == 2'd3);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters with registered sync, video_on and
// pixel coordinates. Define VGA_TIMING_PIXEL_DIV_EN to run from a 4x system clock.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  vga_timing_if.master vga
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : gen_bad_timing
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 12-bit counter range");
  end

  localparam coord_t H_LAST       = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST       = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT        = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT        = coord_t'(V_ACTIVE);
  localparam coord_t H_SYNC_START = coord_t'(H_ACTIVE + H_FRONT);
  localparam coord_t H_SYNC_END   = coord_t'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam coord_t V_SYNC_START = coord_t'(V_ACTIVE + V_FRONT);
  localparam coord_t V_SYNC_END   = coord_t'(V_ACTIVE + V_FRONT + V_SYNC);

  logic tick;

`ifdef VGA_TIMING_PIXEL_DIV_EN
  pixel_tick_gen u_pixel_tick_gen (
    .clock_i (clock),
    .reset_i (reset),
    .tick_o  (tick)
  );
`else
  assign tick = 1'b1;
`endif

  coord_t h_cnt_q, h_cnt_d;
  coord_t v_cnt_q, v_cnt_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   video_on_q, video_on_d;
  logic   frame_start_q, frame_start_d;
  coord_t row_q, row_d;
  coord_t col_q, col_d;
  logic   active;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 12'd1;
      end else begin
        h_cnt_d = h_cnt_q + 12'd1;
      end
    end
  end

  // Outputs are decoded from the pre-tick counters, giving one tick of latency.
  always_comb begin
    active        = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    frame_start_d = frame_start_q;
    row_d         = row_q;
    col_d         = col_q;
    if (tick) begin
      video_on_d    = active;
      col_d         = active ? h_cnt_q : COORD_INVALID;
      row_d         = active ? v_cnt_q : COORD_INVALID;
      hsync_d       = ((h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = ((v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
      row_q         <= COORD_INVALID;
      col_q         <= COORD_INVALID;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
      row_q         <= row_d;
      col_q         <= col_d;
    end
  end

  assign vga.horiz_sync   = hsync_q;
  assign vga.vert_sync    = vsync_q;
  assign vga.video_on     = video_on_q;
  assign vga.frame_start  = frame_start_q;
  assign vga.pixel_row    = row_q;
  assign vga.pixel_column = col_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 instance plus a tiny-raster
// instance for frame-level checks. Works with or without VGA_TIMING_PIXEL_DIV_EN.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

`ifdef VGA_TIMING_PIXEL_DIV_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1;
`endif

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   errors = 0;
  int   checks = 0;

  vga_timing_if vga_a ();
  vga_timing_if vga_b ();

  vga_timing_gen dut_a (
    .clock (clk),
    .reset (rst_a),
    .vga   (vga_a)
  );

  vga_timing_gen #(
    .H_ACTIVE (8),
    .H_FRONT  (2),
    .H_SYNC   (2),
    .H_BACK   (2),
    .V_ACTIVE (4),
    .V_FRONT  (1),
    .V_SYNC   (1),
    .V_BACK   (1)
  ) dut_b (
    .clock (clk),
    .reset (rst_b),
    .vga   (vga_b)
  );

  always #5 clk = ~clk;

  // Advance one pixel tick and sample on the following falling edge.
  task automatic step();
    repeat (DIV) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (vga_a.video_on !== 1'b0) begin
      errors++; $display("FAIL reset_video_on: got %b want 0", vga_a.video_on);
    end
    checks++;
    if ({vga_a.horiz_sync, vga_a.vert_sync} !== 2'b11) begin
      errors++; $display("FAIL reset_syncs: got %b%b want 11", vga_a.horiz_sync, vga_a.vert_sync);
    end
    checks++;
    if ({vga_a.pixel_row, vga_a.pixel_column} !== 24'hFFF_FFF) begin
      errors++;
      $display("FAIL reset_coords: got %h/%h want fff/fff", vga_a.pixel_row, vga_a.pixel_column);
    end
    checks++;
    if (vga_a.frame_start !== 1'b0) begin
      errors++; $display("FAIL reset_frame_start: got %b want 0", vga_a.frame_start);
    end
    rst_a = 1'b0;
    step();
    checks++;
    if ({vga_a.video_on, vga_a.frame_start} !== 2'b11) begin
      errors++;
      $display("FAIL first_tick_flags: got on=%b fs=%b want 1/1", vga_a.video_on, vga_a.frame_start);
    end
    checks++;
    if ({vga_a.pixel_row, vga_a.pixel_column} !== 24'h000_000) begin
      errors++;
      $display("FAIL first_tick_coords: got %h/%h want 000/000", vga_a.pixel_row, vga_a.pixel_column);
    end
    step();
    checks++;
    if ({vga_a.frame_start, vga_a.pixel_column} !== {1'b0, 12'h001}) begin
      errors++;
      $display("FAIL second_tick: got fs=%b col=%h want 0/001", vga_a.frame_start, vga_a.pixel_column);
    end
  endtask

  // Continues from tick 2 of dut_a; tick t reports h_cnt = (t-1) % 800.
  task automatic test_hsync();
    int h, v, hlow, first_low, last_low;
    logic ev, ehs;
    logic [11:0] ec, er;
    hlow = 0; first_low = -1; last_low = -1;
    for (int t = 3; t <= 802; t++) begin
      step();
      h   = (t - 1) % 800;
      v   = (t - 1) / 800;
      ev  = (h < 640);
      ec  = ev ? 12'(h) : 12'hFFF;
      er  = ev ? 12'(v) : 12'hFFF;
      ehs = !((h >= 656) && (h < 752));
      checks++;
      if ({vga_a.video_on, vga_a.pixel_column, vga_a.pixel_row, vga_a.horiz_sync,
           vga_a.vert_sync, vga_a.frame_start} !== {ev, ec, er, ehs, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL line_tick%0d: got on=%b col=%h row=%h hs=%b vs=%b fs=%b want %b %h %h %b 1 0",
                 t, vga_a.video_on, vga_a.pixel_column, vga_a.pixel_row, vga_a.horiz_sync,
                 vga_a.vert_sync, vga_a.frame_start, ev, ec, er, ehs);
      end
      if (vga_a.horiz_sync === 1'b0) begin
        hlow++;
        if (first_low < 0) first_low = t;
        last_low = t;
      end
    end
    checks++;
    if (hlow != 96 || first_low != 657 || last_low != 752) begin
      errors++;
      $display("FAIL hsync_window: got width=%0d ticks %0d..%0d want 96 ticks 657..752",
               hlow, first_low, last_low);
    end
  endtask

  task automatic test_mid_reset();
    for (int t = 803; t <= 1101; t++) step();
    checks++;
    if ({vga_a.pixel_row, vga_a.pixel_column} !== {12'd1, 12'd300}) begin
      errors++;
      $display("FAIL pre_reset_pos: got %0d/%0d want 1/300", vga_a.pixel_row, vga_a.pixel_column);
    end
    rst_a = 1'b1;
    @(negedge clk);
    checks++;
    if ({vga_a.video_on, vga_a.frame_start, vga_a.horiz_sync, vga_a.vert_sync,
         vga_a.pixel_row, vga_a.pixel_column} !== {4'b0011, 24'hFFF_FFF}) begin
      errors++;
      $display("FAIL mid_reset_values: got on=%b fs=%b hs=%b vs=%b %h/%h want 0 0 1 1 fff/fff",
               vga_a.video_on, vga_a.frame_start, vga_a.horiz_sync, vga_a.vert_sync,
               vga_a.pixel_row, vga_a.pixel_column);
    end
    rst_a = 1'b0;
    step();
    checks++;
    if ({vga_a.frame_start, vga_a.pixel_row, vga_a.pixel_column} !== {1'b1, 24'h000_000}) begin
      errors++;
      $display("FAIL restart_origin: got fs=%b %h/%h want 1 000/000",
               vga_a.frame_start, vga_a.pixel_row, vga_a.pixel_column);
    end
  endtask

  // Per-clock view of dut_b after reset: outputs move only on ticks.
  task automatic test_tick_rate();
    int n;
    logic efs;
    logic [11:0] ec;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n   = k / DIV - 1;
      ec  = (n >= 0 && n < 8) ? 12'(n) : 12'hFFF;
      efs = (k / DIV == 1);
      checks++;
      if ({vga_b.pixel_column, vga_b.frame_start} !== {ec, efs}) begin
        errors++;
        $display("FAIL tick_rate_clk%0d: got col=%h fs=%b want %h %b",
                 k, vga_b.pixel_column, vga_b.frame_start, ec, efs);
      end
    end
  endtask

  // dut_b raster: 14 ticks per line, 7 lines, hsync at h 10..11, vsync on line 5.
  task automatic test_small_frame();
    int h, v, hlow, vlow, vfirst;
    int fs_ticks[$];
    logic ev, ehs, evs, efs;
    logic [11:0] ec, er;
    hlow = 0; vlow = 0; vfirst = -1;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    for (int t = 1; t <= 250; t++) begin
      step();
      h   = (t - 1) % 14;
      v   = ((t - 1) / 14) % 7;
      ev  = (h < 8) && (v < 4);
      ec  = ev ? 12'(h) : 12'hFFF;
      er  = ev ? 12'(v) : 12'hFFF;
      ehs = !((h >= 10) && (h < 12));
      evs = (v != 5);
      efs = (h == 0) && (v == 0);
      checks++;
      if ({vga_b.video_on, vga_b.pixel_column, vga_b.pixel_row, vga_b.horiz_sync,
           vga_b.vert_sync, vga_b.frame_start} !== {ev, ec, er, ehs, evs, efs}) begin
        errors++;
        $display("FAIL small_tick%0d: got on=%b col=%h row=%h hs=%b vs=%b fs=%b want %b %h %h %b %b %b",
                 t, vga_b.video_on, vga_b.pixel_column, vga_b.pixel_row, vga_b.horiz_sync,
                 vga_b.vert_sync, vga_b.frame_start, ev, ec, er, ehs, evs, efs);
      end
      if (vga_b.horiz_sync === 1'b0) hlow++;
      if (vga_b.vert_sync === 1'b0) begin
        vlow++;
        if (vfirst < 0) vfirst = t;
      end
      if (vga_b.frame_start === 1'b1) fs_ticks.push_back(t);
    end
    checks++;
    if (fs_ticks.size() != 3) begin
      errors++; $display("FAIL frame_pulses: got %0d pulses want 3", fs_ticks.size());
    end else begin
      checks++;
      if (fs_ticks[1] - fs_ticks[0] != 98 || fs_ticks[2] - fs_ticks[1] != 98) begin
        errors++;
        $display("FAIL frame_period: got %0d,%0d want 98,98",
                 fs_ticks[1] - fs_ticks[0], fs_ticks[2] - fs_ticks[1]);
      end
    end
    checks++;
    if (hlow != 36) begin
      errors++; $display("FAIL small_hsync_total: got %0d want 36", hlow);
    end
    checks++;
    if (vlow != 28 || vfirst != 71) begin
      errors++;
      $display("FAIL small_vsync: got %0d ticks from %0d want 28 from 71", vlow, vfirst);
    end
  endtask

  initial begin
    test_reset();
    test_hsync();
    test_mid_reset();
    test_tick_rate();
    test_small_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
